// File: rtl/motor_pkg.sv
// motor_pkg: shared types and default duty levels for the soft-start motor PWM.
//   estado_rampa_t - ramp FSM states
//   DEF_*          - default duty targets for the 30/50/100 % levels
package motor_pkg;

  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    SUBIENDO = 2'd1,
    BAJANDO  = 2'd2,
    ESTABLE  = 2'd3
  } estado_rampa_t;

  localparam int DEF_PWM_BITS = 8;
  localparam int DEF_DUTY_30  = 77;
  localparam int DEF_DUTY_50  = 128;
  localparam int DEF_DUTY_100 = 255;

endpackage

// File: rtl/pwm_contador.sv
// pwm_contador: free-running PWM counter with period-boundary pulse and
// registered comparator output.
//   clk, reset  - clock, async active-high reset
//   duty        - applied duty (0 = always low, 2**PWM_BITS-1 = always high)
//   pwm_out     - registered (counter < duty)
//   fin_periodo - high the cycle the counter sits at its maximum
module pwm_contador #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PWM_BITS-1:0] duty,
  output logic                pwm_out,
  output logic                fin_periodo
);

  // Counter runs 0..2**PWM_BITS-2 so a period is 2**PWM_BITS-1 clocks and the
  // all-ones duty yields a constant high output.
  localparam logic [PWM_BITS-1:0] CNT_MAX = {{(PWM_BITS-1){1'b1}}, 1'b0};

  logic [PWM_BITS-1:0] r_cnt;
  logic                r_pwm;

  assign fin_periodo = (r_cnt == CNT_MAX);
  assign pwm_out     = r_pwm;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_pwm <= 1'b0;
    end else begin
      r_cnt <= fin_periodo ? '0 : r_cnt + 1'b1;
      r_pwm <= (r_cnt < duty);
    end
  end

endmodule

// File: rtl/pwm_rampa_motor.sv
// pwm_rampa_motor: turns the speed FSM's one-hot level requests into a ramped
// PWM drive for the motor power stage.
//   clk, reset            - clock, async active-high reset
//   sel_30/sel_50/sel_100 - level requests (registered once internally)
//   pwm_out               - registered PWM drive
//   duty_actual           - currently applied duty
//   rampa_activa          - state is SUBIENDO or BAJANDO
//   en_objetivo           - duty reached a non-zero target
//   error_sel             - multi-hot select seen on the previous cycle
// Build option: define FRENO_RAPIDO_EN to drop duty straight to 0 at the next
// period boundary when no level is requested.
module pwm_rampa_motor
  import motor_pkg::*;
#(
  parameter int PWM_BITS = DEF_PWM_BITS,
  parameter int RAMP_DIV = 4,
  parameter int STEP     = 8,
  parameter int DUTY_30  = DEF_DUTY_30,
  parameter int DUTY_50  = DEF_DUTY_50,
  parameter int DUTY_100 = DEF_DUTY_100
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sel_30,
  input  logic                sel_50,
  input  logic                sel_100,
  output logic                pwm_out,
  output logic [PWM_BITS-1:0] duty_actual,
  output logic                rampa_activa,
  output logic                en_objetivo,
  output logic                error_sel
);

  localparam int RC_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [RC_W-1:0]     RC_MAX = RC_W'(RAMP_DIV - 1);
  localparam logic [PWM_BITS:0]   STEP_X = (PWM_BITS+1)'(STEP);
  localparam logic [PWM_BITS-1:0] D30    = PWM_BITS'(DUTY_30);
  localparam logic [PWM_BITS-1:0] D50    = PWM_BITS'(DUTY_50);
  localparam logic [PWM_BITS-1:0] D100   = PWM_BITS'(DUTY_100);

  logic [2:0]          r_sel;
  logic [PWM_BITS-1:0] r_target, r_duty;
  logic [RC_W-1:0]     r_rc;
  logic                r_err;
  estado_rampa_t       r_state, w_state_nxt;

  logic [PWM_BITS-1:0] w_tgt_nxt, w_duty_nxt;
  logic [PWM_BITS:0]   w_duty_x, w_tgt_x;
  logic                w_fin, w_step, w_multi;

  pwm_contador #(.PWM_BITS(PWM_BITS)) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .duty       (r_duty),
    .pwm_out    (pwm_out),
    .fin_periodo(w_fin)
  );

  assign w_multi = (r_sel & (r_sel - 3'd1)) != 3'd0;
  assign w_step  = w_fin && (r_rc == RC_MAX);

  // Target decode; a multi-hot request keeps the previous target.
  always_comb begin
    w_tgt_nxt = r_target;
    case (r_sel)
      3'b000:  w_tgt_nxt = '0;
      3'b001:  w_tgt_nxt = D30;
      3'b010:  w_tgt_nxt = D50;
      3'b100:  w_tgt_nxt = D100;
      default: w_tgt_nxt = r_target;
    endcase
  end

  // Ramp step toward the incoming target, so a target change landing on a
  // step boundary is honoured immediately. Differences are taken in the
  // larger-minus-smaller direction at PWM_BITS+1 bits: no wrap, no overshoot.
  always_comb begin
    w_duty_x   = {1'b0, r_duty};
    w_tgt_x    = {1'b0, w_tgt_nxt};
    w_duty_nxt = r_duty;
    if (w_step) begin
      if (w_duty_x < w_tgt_x)
        w_duty_nxt = ((w_tgt_x - w_duty_x) <= STEP_X) ? w_tgt_nxt
                                                      : PWM_BITS'(w_duty_x + STEP_X);
      else if (w_duty_x > w_tgt_x)
        w_duty_nxt = ((w_duty_x - w_tgt_x) <= STEP_X) ? w_tgt_nxt
                                                      : PWM_BITS'(w_duty_x - STEP_X);
    end
`ifdef FRENO_RAPIDO_EN
    if (w_fin && (w_tgt_nxt == '0))
      w_duty_nxt = '0;
`else
`endif
  end

  // State follows the duty/target relation of the values being registered,
  // so r_state always describes r_duty against r_target.
  always_comb begin
    w_state_nxt  = REPOSO;
    rampa_activa = (r_state == SUBIENDO) || (r_state == BAJANDO);
    en_objetivo  = (r_state == ESTABLE);
    if (w_duty_nxt < w_tgt_nxt)       w_state_nxt = SUBIENDO;
    else if (w_duty_nxt > w_tgt_nxt)  w_state_nxt = BAJANDO;
    else if (w_tgt_nxt != '0)         w_state_nxt = ESTABLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= REPOSO;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sel    <= '0;
      r_target <= '0;
      r_duty   <= '0;
      r_rc     <= '0;
      r_err    <= 1'b0;
    end else begin
      r_sel    <= {sel_100, sel_50, sel_30};
      r_target <= w_tgt_nxt;
      r_duty   <= w_duty_nxt;
      r_err    <= w_multi;
      if (w_state_nxt != r_state) r_rc <= '0;
      else if (w_fin)              r_rc <= (r_rc == RC_MAX) ? '0 : r_rc + 1'b1;
    end
  end

  assign duty_actual = r_duty;
  assign error_sel   = r_err;

endmodule

// File: tb/tb_pwm_rampa_motor.sv
// Directed bench for pwm_rampa_motor with RAMP_DIV=2 (one duty step per 510
// clocks). Expected duty sequences and timings are hand-derived.
module tb_pwm_rampa_motor;

  localparam int STEP     = 8;
  localparam int INTERVAL = 510;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sel_30 = 1'b0, sel_50 = 1'b0, sel_100 = 1'b0;
  logic       pwm_out, rampa_activa, en_objetivo, error_sel;
  logic [7:0] duty_actual;

  int n_chk = 0;
  int n_fail = 0;

  pwm_rampa_motor #(.RAMP_DIV(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .sel_30      (sel_30),
    .sel_50      (sel_50),
    .sel_100     (sel_100),
    .pwm_out     (pwm_out),
    .duty_actual (duty_actual),
    .rampa_activa(rampa_activa),
    .en_objetivo (en_objetivo),
    .error_sel   (error_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Waits (bounded) for duty_actual to move; cyc = clocks waited.
  task automatic wait_change(input int limit, output int cyc);
    logic [7:0] p;
    p = duty_actual;
    cyc = 0;
    while (duty_actual == p && cyc < limit) begin
      tick(1);
      cyc++;
    end
  endtask

  task automatic count_high(input int n, output int hi);
    hi = 0;
    for (int i = 0; i < n; i++) begin
      tick(1);
      if (pwm_out) hi++;
    end
  endtask

  // Follows a ramp to tgt, checking every step value and step spacing.
  task automatic ramp_to(input string tag, input int tgt);
    int cur, expv, cyc;
    bit first;
    cur = duty_actual;
    first = 1'b1;
    while (cur != tgt) begin
      if (cur < tgt) expv = (tgt - cur <= STEP) ? tgt : cur + STEP;
      else           expv = (cur - tgt <= STEP) ? tgt : cur - STEP;
      wait_change(3 * INTERVAL, cyc);
      chk({tag, "_duty"}, duty_actual, expv);
      if (!first) chk({tag, "_interval"}, cyc, INTERVAL);
      if (expv != tgt) chk({tag, "_rampa"}, rampa_activa, 1);
      first = 1'b0;
      cur = expv;
    end
    chk({tag, "_en_obj"}, en_objetivo, 1);
    chk({tag, "_rampa_end"}, rampa_activa, 0);
  endtask

  initial begin
    int hi, cyc, nz;

    // Reset and idle
    tick(3);
    chk("rst_duty", duty_actual, 0);
    chk("rst_pwm", pwm_out, 0);
    chk("rst_err", error_sel, 0);
    @(negedge clk);
    reset = 1'b0;
    hi = 0; nz = 0;
    for (int i = 0; i < 3 * 255; i++) begin
      tick(1);
      if (pwm_out) hi++;
      if (duty_actual != 0 || rampa_activa || en_objetivo) nz++;
    end
    chk("idle_pwm_high", hi, 0);
    chk("idle_nonzero", nz, 0);

    // 30 % ramp from rest
    sel_30 = 1'b1;
    tick(3);
    chk("up30_rampa_start", rampa_activa, 1);
    ramp_to("up30", 77);
    tick(2);
    count_high(255, hi);
    chk("pwm30_high", hi, 77);

    // Redirect to 100 %, last step clamps 253 -> 255
    sel_30 = 1'b0; sel_100 = 1'b1;
    ramp_to("up100", 255);
    tick(2);
    count_high(255, hi);
    chk("pwm100_high", hi, 255);

    // Down to 50 %
    sel_100 = 1'b0; sel_50 = 1'b1;
    tick(3);
    chk("dn50_rampa_start", rampa_activa, 1);
    ramp_to("dn50", 128);
    tick(2);
    count_high(255, hi);
    chk("pwm50_high", hi, 128);

    // Multi-hot select: flag one cycle after the select register samples it
    @(negedge clk);
    sel_50 = 1'b0; sel_30 = 1'b1; sel_100 = 1'b1;
    @(posedge clk); #1;
    chk("err_sample_cycle", error_sel, 0);
    @(posedge clk); #1;
    chk("err_next_cycle", error_sel, 1);
    tick(10);
    chk("err_hold_duty", duty_actual, 128);
    chk("err_hold_target", en_objetivo, 1);
    @(negedge clk);
    sel_30 = 1'b0; sel_100 = 1'b0; sel_50 = 1'b1;
    tick(3);
    chk("err_cleared", error_sel, 0);
    chk("err_after_duty", duty_actual, 128);

    // Drop all selects from 128
    @(negedge clk);
    sel_50 = 1'b0;
    wait_change(3 * INTERVAL, cyc);
`ifdef FRENO_RAPIDO_EN
    chk("freno_duty", duty_actual, 0);
    chk("freno_fast", (cyc <= 260) ? 1 : 0, 1);
    count_high(255, hi);
    chk("freno_pwm_low", hi, 0);
`else
    chk("drop_duty", duty_actual, 120);
    chk("drop_rampa", rampa_activa, 1);
    wait_change(3 * INTERVAL, cyc);
    chk("drop_duty2", duty_actual, 112);
    chk("drop_interval", cyc, INTERVAL);
`endif

    // Reset mid-ramp at duty 40, restart from 0
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sel_50 = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      wait_change(3 * INTERVAL, cyc);
      chk("mid_duty", duty_actual, 8 * k);
    end
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_duty", duty_actual, 0);
    chk("midrst_pwm", pwm_out, 0);
    chk("midrst_rampa", rampa_activa, 0);
    chk("midrst_en", en_objetivo, 0);
    chk("midrst_err", error_sel, 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    wait_change(3 * INTERVAL, cyc);
    chk("restart_duty1", duty_actual, 8);
    wait_change(3 * INTERVAL, cyc);
    chk("restart_duty2", duty_actual, 16);
    chk("restart_interval", cyc, INTERVAL);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
